// File: rtl/uart_sync_fifo_param.sv
// Parametrised single-clock FIFO for the UART TX/RX data paths with occupancy, threshold and sticky error flags.
// Optional feature: define FIFO_FWFT_EN for first-word fall-through reads; default build has a registered 1-cycle read latency.
module uart_sync_fifo_param #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 128,
  parameter int FIFO_BITS  = 7
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic [FIFO_BITS:0]    level,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic [FIFO_BITS:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [FIFO_BITS:0]   DepthCount = (FIFO_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_BITS:0]   CountOne   = (FIFO_BITS+1)'(1);
  localparam logic [FIFO_BITS-1:0] PtrOne     = FIFO_BITS'(1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [FIFO_BITS-1:0]  wrPtr_q, wrPtr_d;
  logic [FIFO_BITS-1:0]  rdPtr_q, rdPtr_d;
  logic [FIFO_BITS:0]    count_q, count_d;
  logic [FIFO_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic isFull, isEmpty;
  logic rdAccept, wrAccept;
  logic overflowEvent, underflowEvent;

  assign isFull  = (count_q == DepthCount);
  assign isEmpty = (count_q == '0);

  // A flush cycle swallows both strobes, so it can neither move data nor raise an error.
  assign rdAccept       = !read_n && !isEmpty && !flush;
  assign wrAccept       = !write_n && (!isFull || rdAccept) && !flush;
  assign overflowEvent  = !write_n && isFull && !rdAccept && !flush;
  assign underflowEvent = !read_n && isEmpty && !flush;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    dataOut_d   = dataOut_q;
    overflow_d  = (overflow_q && !clr_err) || overflowEvent;
    underflow_d = (underflow_q && !clr_err) || underflowEvent;

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrAccept) begin
        wrPtr_d = wrPtr_q + PtrOne;
      end
      if (rdAccept) begin
        rdPtr_d   = rdPtr_q + PtrOne;
        dataOut_d = mem_q[rdPtr_q];
      end
      case ({wrAccept, rdAccept})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dataOut_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      dataOut_q   <= dataOut_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset so it maps onto plain register/LUT RAM.
  always_ff @(posedge clock) begin
    if (reset_n && wrAccept) begin
      mem_q[wrPtr_q] <= data_in;
    end
  end

  assign count     = count_q;
  assign full      = isFull;
  assign empty     = isEmpty;
  assign half      = (count_q >= level);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef FIFO_FWFT_EN
  // Head word falls through while data is present; the last popped word is shown once drained.
  assign data_out = isEmpty ? dataOut_q : mem_q[rdPtr_q];
`else
  assign data_out = dataOut_q;
`endif

endmodule

// File: tb/tb_uart_sync_fifo_param.sv
// Self-checking bench for uart_sync_fifo_param (16x8, level 8) using a queue scoreboard.
// Honours FIFO_FWFT_EN so the same bench checks either read mode.
module tb_uart_sync_fifo_param;

  localparam int W    = 8;
  localparam int D    = 16;
  localparam int BITS = 4;

  logic            clock;
  logic            reset_n;
  logic [W-1:0]    data_in;
  logic            write_n;
  logic            read_n;
  logic            flush;
  logic            clr_err;
  logic [BITS:0]   level;
  logic [W-1:0]    data_out;
  logic [BITS:0]   count;
  logic            full;
  logic            empty;
  logic            half;
  logic            overflow;
  logic            underflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sbQueue[$];
  logic [W-1:0] modelLast;
  bit           modelOvf;
  bit           modelUnf;

  uart_sync_fifo_param #(
    .FIFO_WIDTH(W),
    .FIFO_DEPTH(D),
    .FIFO_BITS (BITS)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .write_n  (write_n),
    .read_n   (read_n),
    .flush    (flush),
    .clr_err  (clr_err),
    .level    (level),
    .data_out (data_out),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .half     (half),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compares every DUT output against the scoreboard model.
  task automatic checkAll(input string tag);
    int unsigned n;
    logic [W-1:0] expData;
    n = sbQueue.size();
`ifdef FIFO_FWFT_EN
    expData = (n != 0) ? sbQueue[0] : modelLast;
`else
    expData = modelLast;
`endif
    checkOutput({tag, ".count"},     32'(count),     32'(n));
    checkOutput({tag, ".full"},      32'(full),      32'(n == D));
    checkOutput({tag, ".empty"},     32'(empty),     32'(n == 0));
    checkOutput({tag, ".half"},      32'(half),      32'(n >= int'(level)));
    checkOutput({tag, ".overflow"},  32'(overflow),  32'(modelOvf));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(modelUnf));
    checkOutput({tag, ".data_out"},  32'(data_out),  32'(expData));
  endtask

  // Drives one cycle of strobes, advances the model across the edge and checks after it.
  task automatic applyStimulus(input string tag, input bit wr, input logic [W-1:0] d,
                               input bit rd, input bit fl, input bit clr);
    bit mFull, mEmpty, rdAcc, wrAcc, ovfEv, unfEv;
    write_n = !wr;
    read_n  = !rd;
    data_in = d;
    flush   = fl;
    clr_err = clr;
    mFull  = (sbQueue.size() == D);
    mEmpty = (sbQueue.size() == 0);
    rdAcc  = rd && !mEmpty && !fl;
    wrAcc  = wr && (!mFull || rdAcc) && !fl;
    ovfEv  = wr && mFull && !rdAcc && !fl;
    unfEv  = rd && mEmpty && !fl;
    @(posedge clock);
    #1;
    if (fl) begin
      sbQueue.delete();
    end else begin
      if (rdAcc) modelLast = sbQueue.pop_front();
      if (wrAcc) sbQueue.push_back(d);
    end
    modelOvf = (modelOvf && !clr) || ovfEv;
    modelUnf = (modelUnf && !clr) || unfEv;
    write_n = 1'b1;
    read_n  = 1'b1;
    flush   = 1'b0;
    clr_err = 1'b0;
    checkAll(tag);
  endtask

  task automatic doReset(input string tag, input bit keepWrite);
    reset_n = 1'b0;
    write_n = !keepWrite;
    data_in = 8'hEE;
    read_n  = 1'b1;
    flush   = 1'b0;
    clr_err = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    write_n = 1'b1;
    sbQueue.delete();
    modelLast = '0;
    modelOvf  = 1'b0;
    modelUnf  = 1'b0;
    checkAll(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    data_in = '0;
    write_n = 1'b1;
    read_n  = 1'b1;
    flush   = 1'b0;
    clr_err = 1'b0;
    level   = 5'd8;
    modelLast = '0;
    modelOvf  = 1'b0;
    modelUnf  = 1'b0;

    doReset("reset", 1'b0);

    for (int i = 1; i <= D; i++) applyStimulus("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);

    applyStimulus("ovf_write", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    applyStimulus("ovf_setwins", 1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
    applyStimulus("ovf_clear", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < D; i++) applyStimulus("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    applyStimulus("unf_read", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("unf_rdwr", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    applyStimulus("read_55", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("unf_clear", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < D; i++) applyStimulus("refill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus("full_rdwr", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < D; i++) applyStimulus("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) applyStimulus("pre_flush", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus("flush_wr", 1'b1, 8'hDD, 1'b0, 1'b1, 1'b0);
    applyStimulus("flush_rd_empty", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("post_flush", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus("post_flush_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("flush_rd", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 7; i++) applyStimulus("burst", 1'b1, 8'(8'h60 + i), (i % 2) == 1, 1'b0, 1'b0);
    doReset("reset_mid", 1'b1);

    level = 5'd0;
    applyStimulus("level0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    level = 5'd16;
    for (int i = 0; i < D; i++) applyStimulus("level16", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    level = 5'd17;
    applyStimulus("level17", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    level = 5'd31;
    applyStimulus("level31", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    level = 5'd8;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] rv;
      rv = 8'($urandom_range(0, 255));
      applyStimulus("random", ($urandom_range(0, 1) == 1), rv, ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
